os_exec_ctrl: RTL and testbench

//  Output-stationary sequencer for core. Replaces hand-driven bench sequencing of one tile:
//  - issues LEN_NIJ activation/weight fetch pairs from xmem, flow-controlled by l0_ready/ififo_ready
//  - shifts the array out for DRAIN_CYC cycles
//  - reads COL words from the OFIFO

---
 rtl/os_exec_ctrl_if.sv | 37 +++
 rtl/os_exec_ctrl.sv | 168 ++++++++++++++++
 tb/tb_os_exec_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/os_exec_ctrl_if.sv
// Handshake and instruction-field bundle between the tile sequencer and its
// surroundings: start/abort/done toward the top level, fetch and array
// strobes toward the core, ready/valid flow control back from L0/IFIFO/OFIFO.
interface os_exec_ctrl_if #(
  parameter int XA_W = 8
);
  logic            start;
  logic            abort;
  logic            l0_ready;
  logic            ififo_ready;
  logic            ofifo_valid;
  logic            CEN0_xmem;
  logic            WEN0_xmem;
  logic [XA_W-1:0] A0_xmem;
  logic            CEN1_xmem;
  logic [XA_W-1:0] A1_xmem;
  logic            mode;
  logic            execute;
  logic            load;
  logic            ofifo_rd;
  logic            busy;
  logic            done;

  // Sequencer side.
  modport slave (
    input  start, abort, l0_ready, ififo_ready, ofifo_valid,
    output CEN0_xmem, WEN0_xmem, A0_xmem, CEN1_xmem, A1_xmem,
           mode, execute, load, ofifo_rd, busy, done
  );

  // Side that starts tiles and models the core's flow control.
  modport master (
    output start, abort, l0_ready, ififo_ready, ofifo_valid,
    input  CEN0_xmem, WEN0_xmem, A0_xmem, CEN1_xmem, A1_xmem,
           mode, execute, load, ofifo_rd, busy, done
  );
endinterface

// File: rtl/os_exec_ctrl.sv
// Output-stationary tile sequencer: issues LEN_NIJ activation/weight fetch
// pairs under L0/IFIFO back-pressure, shifts the array out for DRAIN_CYC
// cycles, pops COL OFIFO words, then pulses done. All outputs are registered
// except ofifo_rd, which must follow ofifo_valid within the same cycle.
module os_exec_ctrl #(
  parameter int              LEN_NIJ   = 72,
  parameter int              DRAIN_CYC = 16,
  parameter int              COL       = 8,
  parameter int              XA_W      = 8,
  parameter logic [XA_W-1:0] ACT_BASE  = '0,
  parameter logic [XA_W-1:0] W_BASE    = XA_W'(8'h80)
) (
  input  logic         clk,
  input  logic         reset,
  os_exec_ctrl_if.slave bus
);

  localparam int K_W = $clog2(LEN_NIJ + 1);
  localparam int D_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int R_W = (COL > 1) ? $clog2(COL) : 1;
  localparam logic [K_W-1:0] K_END  = K_W'(LEN_NIJ);
  localparam logic [D_W-1:0] D_LAST = D_W'(DRAIN_CYC - 1);
  localparam logic [R_W-1:0] R_LAST = R_W'(COL - 1);

  // Activation rows must not run into the weight region of xmem.
  if (LEN_NIJ > (int'(W_BASE) - int'(ACT_BASE))) begin : g_len_check
    $error("os_exec_ctrl: LEN_NIJ overlaps the weight region at W_BASE");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_READ,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [K_W-1:0]  k_q, k_d;        // fetch pairs issued so far
  logic [D_W-1:0]  d_q, d_d;        // drain cycles elapsed
  logic [R_W-1:0]  r_q, r_d;        // OFIFO words popped
  logic [XA_W-1:0] a0_q, a0_d;
  logic [XA_W-1:0] a1_q, a1_d;
  logic            cen_q, cen_d;    // shared by both xmem ports
  logic            exec_q, exec_d;
  logic            load_q, load_d;
  logic            active_q, active_d; // drives both busy and mode
  logic            done_q, done_d;
  logic            pop;

  assign pop = (state_q == S_READ) && bus.ofifo_valid;

  // Next-state and next-output logic; outputs are derived from the next state
  // so that each registered output lines up with the state it describes.
  always_comb begin
    // NOTE: every _d signal gets a default first, so no branch can leave one unassigned and infer a latch.
    state_d = state_q;
    k_d     = k_q;
    d_d     = d_q;
    r_d     = r_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    cen_d   = 1'b1;
    exec_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FEED;
          k_d     = '0;
        end
      end
      S_FEED: begin
        // The last issue is visible on the outputs for one FEED cycle before
        // the drain begins, so execute and load never overlap.
        if (k_q == K_END) begin
          state_d = S_DRAIN;
          d_d     = '0;
        end else if (bus.l0_ready && bus.ififo_ready) begin
          cen_d  = 1'b0;
          exec_d = 1'b1;
          a0_d   = ACT_BASE + XA_W'(k_q);
          a1_d   = W_BASE + XA_W'(k_q);
          k_d    = k_q + K_W'(1);
        end
      end
      S_DRAIN: begin
        if (d_q == D_LAST) begin
          state_d = S_READ;
          r_d     = '0;
        end else begin
          d_d = d_q + D_W'(1);
        end
      end
      S_READ: begin
        if (pop) begin
          r_d = r_q + R_W'(1);
          if (r_q == R_LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over every transition and clears the block like a reset.
    if (bus.abort) begin
      state_d = S_IDLE;
      k_d     = '0;
      d_d     = '0;
      r_d     = '0;
      a0_d    = '0;
      a1_d    = '0;
      cen_d   = 1'b1;
      exec_d  = 1'b0;
    end

    active_d = (state_d != S_IDLE);
    load_d   = (state_d == S_DRAIN);
    done_d   = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
    if (!reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      a0_q     <= '0;
      a1_q     <= '0;
      cen_q    <= 1'b1;
      exec_q   <= 1'b0;
      load_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      d_q      <= d_d;
      r_q      <= r_d;
      a0_q     <= a0_d;
      a1_q     <= a1_d;
      cen_q    <= cen_d;
      exec_q   <= exec_d;
      load_q   <= load_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign bus.CEN0_xmem = cen_q;
  assign bus.CEN1_xmem = cen_q;
  assign bus.WEN0_xmem = 1'b1;     // this block only ever reads xmem
  assign bus.A0_xmem   = a0_q;
  assign bus.A1_xmem   = a1_q;
  assign bus.mode      = active_q;
  assign bus.busy      = active_q;
  assign bus.execute   = exec_q;
  assign bus.load      = load_q;
  assign bus.done      = done_q;
  assign bus.ofifo_rd  = pop;

endmodule

// File: tb/tb_os_exec_ctrl.sv
// Bench for os_exec_ctrl with a short tile (LEN_NIJ=4). For each tile the
// expected per-cycle outputs are derived as a timeline from the ready/valid
// patterns: issue n lands one cycle after the n-th cycle with both readies
// high, the drain follows the last issue, pops follow valid, done follows the
// COL-th pop.
module tb_os_exec_ctrl;

  localparam int         LEN   = 4;
  localparam int         DRN   = 16;
  localparam int         NCOL  = 8;
  localparam int         MAXT  = 400;
  localparam logic [7:0] ACT_B = 8'h00;
  localparam logic [7:0] W_B   = 8'h80;

  typedef struct packed {
    logic       busy;
    logic       mode;
    logic       done;
    logic       load;
    logic       execute;
    logic       ofifo_rd;
    logic       cen0;
    logic       cen1;
    logic       wen0;
    logic [7:0] a0;
    logic [7:0] a1;
  } outs_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bit         rdy0 [MAXT];
  bit         rdy1 [MAXT];
  bit         vld  [MAXT];
  bit         stt  [MAXT];
  logic [7:0] issued_q[$];
  int         pops_seen;
  bit         tile_aborted;
  logic [7:0] hold_a0;
  logic [7:0] hold_a1;

  os_exec_ctrl_if #(.XA_W(8)) bus ();

  os_exec_ctrl #(
    .LEN_NIJ  (LEN),
    .DRAIN_CYC(DRN),
    .COL      (NCOL),
    .XA_W     (8),
    .ACT_BASE (ACT_B),
    .W_BASE   (W_B)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic outs_t sample();
    outs_t o;
    o.busy     = bus.busy;
    o.mode     = bus.mode;
    o.done     = bus.done;
    o.load     = bus.load;
    o.execute  = bus.execute;
    o.ofifo_rd = bus.ofifo_rd;
    o.cen0     = bus.CEN0_xmem;
    o.cen1     = bus.CEN1_xmem;
    o.wen0     = bus.WEN0_xmem;
    o.a0       = bus.A0_xmem;
    o.a1       = bus.A1_xmem;
    return o;
  endfunction

  function automatic outs_t idle_outs(input logic [7:0] a0, input logic [7:0] a1);
    outs_t o;
    o = '0;
    o.cen0 = 1'b1;
    o.cen1 = 1'b1;
    o.wen0 = 1'b1;
    o.a0   = a0;
    o.a1   = a1;
    return o;
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("busy=%b mode=%b done=%b load=%b exe=%b rd=%b cen0=%b cen1=%b wen0=%b a0=%h a1=%h",
                     o.busy, o.mode, o.done, o.load, o.execute, o.ofifo_rd,
                     o.cen0, o.cen1, o.wen0, o.a0, o.a1);
  endfunction

  // True when the recorded fetch addresses are exactly ACT_B+0..LEN-1 in order.
  function automatic bit seq_ok();
    if (issued_q.size() != LEN) return 1'b0;
    for (int i = 0; i < LEN; i++)
      if (issued_q[i] !== ACT_B + 8'(i)) return 1'b0;
    return 1'b1;
  endfunction

  // Runs one tile from an IDLE negedge to the negedge of the cycle after it
  // ends. rmode: 0 readies high, 1 random, 2 ififo_ready low in cycles 2..3.
  // vmode: 0 valid high in READ, 1 alternating 1,0.., 2 random.
  // abort_sel: -1 none, -2 random cycle before done, -3 fifth drain cycle.
  task automatic run_tile(input string name, input int rmode, input int vmode,
                          input bit hold_start, input bit noise_start, input int abort_sel);
    bit         issue_at [MAXT];
    int         issue_idx[MAXT];
    int         n, t_last, r0, npop, t_pop, t_done, t_end, abort_at;
    logic [7:0] cur_a0, cur_a1;
    outs_t      exp_o, got_o;

    for (int t = 0; t < MAXT; t++) begin
      issue_at[t]  = 1'b0;
      issue_idx[t] = 0;
      rdy0[t]      = 1'b1;
      rdy1[t]      = 1'b1;
      if (rmode == 1 && t < 100) begin
        rdy0[t] = ($urandom_range(0, 3) != 0);
        rdy1[t] = ($urandom_range(0, 3) != 0);
      end
      if (rmode == 2 && (t == 2 || t == 3)) rdy1[t] = 1'b0;
    end

    n      = 0;
    t_last = 0;
    for (int t = 0; t < MAXT - 1 && n < LEN; t++) begin
      if (rdy0[t] && rdy1[t]) begin
        issue_at[t+1]  = 1'b1;
        issue_idx[t+1] = n;
        n++;
        t_last = t + 1;
      end
    end
    r0 = t_last + DRN + 1;

    for (int t = 0; t < MAXT; t++) begin
      if (t < r0)          vld[t] = 1'($urandom_range(0, 1));
      else if (vmode == 0) vld[t] = 1'b1;
      else if (vmode == 1) vld[t] = ((t - r0) % 2 == 0);
      else                 vld[t] = (t - r0 < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    npop  = 0;
    t_pop = r0;
    for (int t = r0; t < MAXT && npop < NCOL; t++) begin
      if (vld[t]) begin
        npop++;
        t_pop = t;
      end
    end
    t_done = t_pop + 1;

    for (int t = 0; t < MAXT; t++)
      stt[t] = noise_start ? 1'($urandom_range(0, 1)) : hold_start;

    if (abort_sel == -2)      abort_at = $urandom_range(0, t_done - 1);
    else if (abort_sel == -3) abort_at = t_last + 5;
    else                      abort_at = -1;
    t_end        = (abort_at >= 0) ? abort_at + 1 : t_done + 1;
    tile_aborted = (abort_at >= 0);

    issued_q.delete();
    pops_seen = 0;
    cur_a0    = hold_a0;
    cur_a1    = hold_a1;

    bus.start = 1'b1;
    bus.abort = 1'b0;
    @(posedge clk);
    #1;
    for (int t = 0; t <= t_end; t++) begin
      bus.start       = (t == t_end) ? hold_start : stt[t];
      bus.abort       = (t == abort_at);
      bus.l0_ready    = rdy0[t];
      bus.ififo_ready = rdy1[t];
      bus.ofifo_valid = vld[t];

      if (issue_at[t]) begin
        cur_a0 = ACT_B + 8'(issue_idx[t]);
        cur_a1 = W_B + 8'(issue_idx[t]);
      end
      if (abort_at >= 0 && t == abort_at + 1) begin
        cur_a0 = 8'h00;
        cur_a1 = 8'h00;
        exp_o  = idle_outs(cur_a0, cur_a1);
      end else begin
        exp_o.busy     = (t <= t_done);
        exp_o.mode     = (t <= t_done);
        exp_o.done     = (t == t_done);
        exp_o.load     = (t > t_last) && (t <= t_last + DRN);
        exp_o.execute  = issue_at[t];
        exp_o.ofifo_rd = (t >= r0) && (t <= t_pop) && vld[t];
        exp_o.cen0     = !issue_at[t];
        exp_o.cen1     = !issue_at[t];
        exp_o.wen0     = 1'b1;
        exp_o.a0       = cur_a0;
        exp_o.a1       = cur_a1;
      end

      @(negedge clk);
      got_o = sample();
      checks++;
      if (got_o !== exp_o) begin
        errors++;
        $display("FAIL %s cycle %0d: got %s | expected %s", name, t, fmt(got_o), fmt(exp_o));
      end
      if (got_o.cen0 === 1'b0) issued_q.push_back(got_o.a0);
      if (got_o.ofifo_rd === 1'b1) pops_seen++;
      if (t < t_end) begin
        @(posedge clk);
        #1;
      end
    end
    hold_a0 = cur_a0;
    hold_a1 = cur_a1;
  endtask

  task automatic test_reset();
    outs_t got_o;
    reset           = 1'b0;
    bus.start       = 1'b1;
    bus.abort       = 1'b0;
    bus.l0_ready    = 1'b1;
    bus.ififo_ready = 1'b1;
    bus.ofifo_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got_o = sample();
      checks++;
      if (got_o !== idle_outs(8'h00, 8'h00)) begin
        errors++;
        $display("FAIL reset cycle %0d: got %s | expected %s", i, fmt(got_o), fmt(idle_outs(8'h00, 8'h00)));
      end
    end
    reset     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    got_o = sample();
    checks++;
    if (got_o !== idle_outs(8'h00, 8'h00)) begin
      errors++;
      $display("FAIL reset_release: got %s | expected %s", fmt(got_o), fmt(idle_outs(8'h00, 8'h00)));
    end
    hold_a0 = 8'h00;
    hold_a1 = 8'h00;
  endtask

  task automatic test_basic();
    run_tile("basic", 0, 0, 1'b0, 1'b0, -1);
    checks++;
    if (!seq_ok() || pops_seen != NCOL) begin
      errors++;
      $display("FAIL basic_totals: got %0d issues, %0d pops | expected %0d issues, %0d pops",
               issued_q.size(), pops_seen, LEN, NCOL);
    end
  endtask

  task automatic test_stall();
    run_tile("stall", 2, 0, 1'b0, 1'b0, -1);
    checks++;
    if (!seq_ok()) begin
      errors++;
      $display("FAIL stall_sequence: got %0d issues (%p) | expected addresses 0..%0d once each",
               issued_q.size(), issued_q, LEN - 1);
    end
  endtask

  task automatic test_valid_toggle();
    run_tile("valid_toggle", 0, 1, 1'b0, 1'b0, -1);
    checks++;
    if (pops_seen != NCOL) begin
      errors++;
      $display("FAIL valid_toggle_pops: got %0d | expected %0d", pops_seen, NCOL);
    end
  endtask

  task automatic test_abort();
    outs_t got_o;
    run_tile("abort_drain", 0, 0, 1'b0, 1'b0, -3);
    run_tile("after_abort", 0, 0, 1'b0, 1'b0, -1);
    checks++;
    if (issued_q.size() == 0 || issued_q[0] !== ACT_B || !seq_ok()) begin
      errors++;
      $display("FAIL restart_after_abort: got %0d issues, first %h | expected %0d issues from %h",
               issued_q.size(), (issued_q.size() > 0) ? issued_q[0] : 8'hxx, LEN, ACT_B);
    end
    // abort outranks start when both arrive in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    got_o = sample();
    checks++;
    if (got_o !== idle_outs(8'h00, 8'h00)) begin
      errors++;
      $display("FAIL abort_vs_start: got %s | expected %s", fmt(got_o), fmt(idle_outs(8'h00, 8'h00)));
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    hold_a0   = 8'h00;
    hold_a1   = 8'h00;
  endtask

  task automatic test_mid_reset();
    outs_t got_o;
    bus.l0_ready    = 1'b1;
    bus.ififo_ready = 1'b1;
    bus.ofifo_valid = 1'b1;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    got_o = sample();
    checks++;
    if (got_o !== idle_outs(8'h00, 8'h00)) begin
      errors++;
      $display("FAIL mid_reset: got %s | expected %s", fmt(got_o), fmt(idle_outs(8'h00, 8'h00)));
    end
    hold_a0 = 8'h00;
    hold_a1 = 8'h00;
  endtask

  task automatic test_back_to_back();
    run_tile("start_held_1", 0, 0, 1'b1, 1'b0, -1);
    run_tile("start_held_2", 0, 2, 1'b0, 1'b0, -1);
    checks++;
    if (!seq_ok() || pops_seen != NCOL) begin
      errors++;
      $display("FAIL back_to_back_totals: got %0d issues, %0d pops | expected %0d issues, %0d pops",
               issued_q.size(), pops_seen, LEN, NCOL);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_tile($sformatf("random_%0d", i), 1, 2, 1'b0, 1'b1, ($urandom_range(0, 3) == 0) ? -2 : -1);
      if (!tile_aborted) begin
        checks++;
        if (!seq_ok() || pops_seen != NCOL) begin
          errors++;
          $display("FAIL random_%0d_totals: got %0d issues, %0d pops | expected %0d issues, %0d pops",
                   i, issued_q.size(), pops_seen, LEN, NCOL);
        end
      end
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.l0_ready    = 1'b0;
    bus.ififo_ready = 1'b0;
    bus.ofifo_valid = 1'b0;
    hold_a0         = 8'h00;
    hold_a1         = 8'h00;

    test_reset();
    test_basic();
    test_stall();
    test_valid_toggle();
    test_abort();
    test_mid_reset();
    test_back_to_back();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
